// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master and slave.
//   spi_state_e   : transfer FSM states (idle / active)
//   SPI_DATA_W    : default bits per transfer
//   SPI_IDLE_BYTE : default byte shifted out when nothing is queued
package spi_pkg;

  localparam int unsigned SPI_DATA_W    = 8;
  localparam logic [7:0]  SPI_IDLE_BYTE = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchroniser for an asynchronous pin, plus one extra
// flop so single-cycle rise/fall pulses can be derived in the clk domain.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   d_i    : asynchronous input pin
//   sync_o : synchronised level
//   rise_o : one-cycle pulse on a synchronised 0->1 transition
//   fall_o : one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the pin's idle level so leaving reset never produces a
  // spurious edge pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 byte slave, oversampled in the clk domain.
//   clk, rst          : system clock, synchronous active-high reset
//   SCLK, MOSI, SS    : SPI pins from the master (SS active-low)
//   MISO              : registered serial data to the master, 0 when idle
//   tx_data, start    : byte offered for the next transfer slot
//   tx_ready          : transmit buffer empty, a start is accepted
//   rx_data           : last complete received byte
//   done              : one-cycle pulse when a byte has been received
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | SS high; SCLK ignored, MISO driven 0
// ST_ACTIVE | SS low; bits shift on SCLK rise (in) and fall (out)
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = SPI_DATA_W,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(SPI_IDLE_BYTE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              done
);

  localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // Pin synchronisation
  logic sclk_sync_unused;
  logic sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_sclk (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (SCLK),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_ss (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (SS),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // MOSI needs only the level; it is sampled on the detected SCLK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Datapath and FSM registers
  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              reload_q, reload_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic              done_pend_q, done_pend_d;
  logic              done_q;
  logic              miso_q, miso_d;
  logic              load;
  logic [DATA_W-1:0] rx_next;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_buf_d    = tx_buf_q;
    tx_ready_d  = tx_ready_q;
    done_pend_d = 1'b0;
    load        = 1'b0;
    rx_next     = {rx_shift_q, mosi_s};

    if (ss_rise) begin
      // Abort: partial byte is dropped, the unsent tx_shift is discarded,
      // but a byte waiting in tx_buf survives for the next SS assertion.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      reload_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (ss_fall) begin
        state_d   = ST_ACTIVE;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        load      = 1'b1;
      end
    end else begin
      if (sclk_rise) begin
        rx_shift_d = rx_next[DATA_W-2:0];
        if (bit_cnt_q == LAST_BIT) begin
          rx_data_d   = rx_next;
          done_pend_d = 1'b1;
          bit_cnt_d   = '0;
          reload_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      // The fall after the last bit's rise starts the next byte instead of
      // shifting, so back-to-back bytes need no SS toggle.
      if (sclk_fall) begin
        if (reload_q) begin
          load     = 1'b1;
          reload_d = 1'b0;
        end else begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
    end

    // A load has priority over start; a held start is taken next cycle.
    if (load) begin
      tx_shift_d = tx_ready_q ? IDLE_BYTE : tx_buf_q;
      tx_ready_d = 1'b1;
    end else if (start && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    miso_d = ((state_q == ST_ACTIVE) && !ss_sync) ? tx_shift_q[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_pend_q;
      miso_q      <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       SS = 1'b1;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic       start = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int dc_snap;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       done_prev = 1'b0;
  logic [7:0] got;
  logic [7:0] tmp_got;
  logic [7:0] b2b_got[4];

  always #5 clk = ~clk;

  spi_slave #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .IDLE_BYTE   (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .SS       (SS),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .start    (start),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .done     (done)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected received byte.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected_done: got %h expected no done", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check8("rx_data", rx_data, mon_exp);
      end
      check8("done_width", {7'd0, done_prev}, 8'd0);
    end
    done_prev = done;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = d[7-i];
      wait_clk(HALF);
      rcv = {rcv[6:0], MISO};
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic ss_assert();
    SS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_release();
    wait_clk(HALF);
    SS = 1'b1;
    wait_clk(HALF + 4);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data = d;
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      wait_clk(1);
      if (!tx_ready) break;
    end
    start = 1'b0;
    check8("tx_accept", {7'd0, tx_ready}, 8'd0);
  endtask

  task automatic xfer(input logic [7:0] mosi_b, input logic [7:0] exp_miso, input string name);
    logic [7:0] r;
    exp_q.push_back(mosi_b);
    ss_assert();
    spi_bits(mosi_b, 8, r);
    ss_release();
    check8(name, r, exp_miso);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 400) begin
      wait_clk(1);
      k++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL refill_wait_done: got timeout expected done pulse");
    end
  endtask

  initial begin
    wait_clk(4);
    check8("rst_miso", {7'd0, MISO}, 8'd0);
    check8("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
    check8("rst_done", {7'd0, done}, 8'd0);
    check8("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wait_clk(4);

    // Single byte loop-back
    push_tx(8'hA5);
    xfer(8'hF0, 8'hA5, "miso_a5");
    check8("tx_ready_after_load", {7'd0, tx_ready}, 8'd1);

    // Four back-to-back bytes under one SS, buffer refilled after each done
    push_tx(8'h11);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    ss_assert();
    fork
      begin
        spi_bits(8'hF0, 8, tmp_got); b2b_got[0] = tmp_got;
        spi_bits(8'h0F, 8, tmp_got); b2b_got[1] = tmp_got;
        spi_bits(8'hAA, 8, tmp_got); b2b_got[2] = tmp_got;
        spi_bits(8'h55, 8, tmp_got); b2b_got[3] = tmp_got;
      end
      begin
        wait_done(); push_tx(8'h22);
        wait_done(); push_tx(8'h33);
        wait_done(); push_tx(8'h44);
      end
    join
    ss_release();
    check8("b2b_miso0", b2b_got[0], 8'h11);
    check8("b2b_miso1", b2b_got[1], 8'h22);
    check8("b2b_miso2", b2b_got[2], 8'h33);
    check8("b2b_miso3", b2b_got[3], 8'h44);

    // No start: idle byte goes out
    xfer(8'h3C, 8'h00, "miso_idle_byte");

    // Abort after five rising edges
    dc_snap = done_cnt;
    ss_assert();
    spi_bits(8'hE7, 5, got);
    ss_release();
    wait_clk(8);
    check_int("abort_no_done", done_cnt, dc_snap);
    check8("abort_rx_kept", rx_data, 8'h3C);
    xfer(8'h81, 8'h00, "miso_after_abort");

    // start while buffer full is ignored
    push_tx(8'h12);
    tx_data = 8'h77;
    start = 1'b1;
    wait_clk(3);
    start = 1'b0;
    check8("full_tx_ready", {7'd0, tx_ready}, 8'd0);
    xfer(8'h5A, 8'h12, "miso_buffered");

    // Reset in the middle of a byte
    push_tx(8'hF1);
    ss_assert();
    spi_bits(8'h00, 3, got);
    wait_clk(4);
    check8("mid_miso", {7'd0, MISO}, 8'd1);
    push_tx(8'h9E);
    dc_snap = done_cnt;
    rst = 1'b1;
    SS = 1'b1;
    SCLK = 1'b0;
    wait_clk(1);
    check8("mid_rst_miso", {7'd0, MISO}, 8'd0);
    check8("mid_rst_tx_ready", {7'd0, tx_ready}, 8'd1);
    check8("mid_rst_done", {7'd0, done}, 8'd0);
    check8("mid_rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wait_clk(4);
    check_int("mid_rst_no_done", done_cnt, dc_snap);
    xfer(8'hC3, 8'h00, "miso_post_rst");

    wait_clk(20);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
